// File: rtl/board_pkg.sv
// board_pkg: shared colours, FSM states and cell indexing for the board renderer
// Contents: BOARD_N, COL_* colour codes, state_t encoding, cell_idx(r,c) = r*8+c
package board_pkg;
  localparam int BOARD_N = 8;
  localparam logic [2:0] COL_EMPTY    = 3'b000;
  localparam logic [2:0] COL_BORDER   = 3'b111;
  localparam logic [2:0] COL_FILLED   = 3'b011;
  localparam logic [2:0] COL_ACTIVE   = 3'b110;
  localparam logic [2:0] COL_CONFLICT = 3'b100;
  localparam logic [2:0] COL_OVER     = 3'b101;
  typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_DONE} state_t;
  function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
    return {r, c};
  endfunction
endpackage

// File: rtl/board_scan_counter.sv
// board_scan_counter: nested raster counters over the 8x8 board with screen coordinates
// Ports: clk, reset (async), clear (back to first pixel), advance (step one pixel);
//        r/c cell row/col, pix_edge (border pixel), last (final pixel), x/y screen position
module board_scan_counter
  import board_pkg::*;
#(
  parameter int CELL_PX  = 12,
  parameter int ORIGIN_X = 16,
  parameter int ORIGIN_Y = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  output logic [2:0] r,
  output logic [2:0] c,
  output logic       pix_edge,
  output logic       last,
  output logic [7:0] x,
  output logic [6:0] y
);
  localparam int PW = $clog2(CELL_PX + 1);
  localparam logic [PW-1:0] PX_MAX = PW'(CELL_PX - 1);
  logic [PW-1:0] px, py;
  logic px_end, c_end, py_end, r_end, row_end;
  assign px_end   = px == PX_MAX;
  assign py_end   = py == PX_MAX;
  assign c_end    = c == 3'(BOARD_N - 1);
  assign r_end    = r == 3'(BOARD_N - 1);
  assign row_end  = px_end && c_end;
  assign pix_edge = px_end || py_end;
  assign last     = row_end && py_end && r_end;
  // x/y track the screen position incrementally so no multiply by CELL_PX is needed
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      px <= '0;
      py <= '0;
      c  <= '0;
      r  <= '0;
      x  <= 8'(ORIGIN_X);
      y  <= 7'(ORIGIN_Y);
    end else if (clear) begin
      px <= '0;
      py <= '0;
      c  <= '0;
      r  <= '0;
      x  <= 8'(ORIGIN_X);
      y  <= 7'(ORIGIN_Y);
    end else if (advance) begin
      px <= px_end ? '0 : px + 1'b1;
      c  <= px_end ? c + 3'd1 : c;
      x  <= row_end ? 8'(ORIGIN_X) : x + 8'd1;
      py <= row_end ? (py_end ? '0 : py + 1'b1) : py;
      r  <= row_end && py_end ? r + 3'd1 : r;
      y  <= row_end ? (py_end && r_end ? 7'(ORIGIN_Y) : y + 7'd1) : y;
    end
endmodule

// File: rtl/board_renderer.sv
// board_renderer: rasterises the 8x8 board, active block and game-over state into VGA pixel writes
// Ports: clk, reset (async, active-high), start (redraw request, IDLE only), game_grid/active_block
//        (bit r*8+c), active_x/active_y (block origin), game_over; busy, done (1-cycle pulse),
//        vga_x/vga_y/vga_colour/vga_plot (one registered pixel per clock)
module board_renderer
  import board_pkg::*;
#(
  parameter int CELL_PX  = 12,
  parameter int ORIGIN_X = 16,
  parameter int ORIGIN_Y = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] game_grid,
  input  logic [63:0] active_block,
  input  logic [2:0]  active_x,
  input  logic [2:0]  active_y,
  input  logic        game_over,
  output logic        busy,
  output logic        done,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);
  if (ORIGIN_X + BOARD_N * CELL_PX > 160 || ORIGIN_Y + BOARD_N * CELL_PX > 120) begin : g_bad_geometry
    $error("board_renderer: board does not fit on the 160x120 screen");
  end
  state_t      state;
  logic [63:0] grid_s, block_s, g, b;
  logic [2:0]  ax_s, ay_s, ax, ay, dr, dc, r, c, col;
  logic        go_s, go, hit, ov, idle, advance, pix_edge, last;
  logic [7:0]  sx;
  logic [6:0]  sy;
  assign idle    = state == ST_IDLE;
  assign advance = (idle && start) || state == ST_DRAW;
  board_scan_counter #(
    .CELL_PX (CELL_PX),
    .ORIGIN_X(ORIGIN_X),
    .ORIGIN_Y(ORIGIN_Y)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .clear   (!advance),
    .advance (advance),
    .r       (r),
    .c       (c),
    .pix_edge(pix_edge),
    .last    (last),
    .x       (sx),
    .y       (sy)
  );
  // The first pixel is emitted on the start edge itself, before the snapshot
  // registers load, so it reads the live inputs that are being captured.
  always_comb begin
    g   = idle ? game_grid : grid_s;
    b   = idle ? active_block : block_s;
    ax  = idle ? active_x : ax_s;
    ay  = idle ? active_y : ay_s;
    go  = idle ? game_over : go_s;
    dr  = r - ay;
    dc  = c - ax;
    hit = g[cell_idx(r, c)];
    ov  = !go && r >= ay && c >= ax && b[cell_idx(dr, dc)];
    col = pix_edge ? COL_BORDER :
          go && hit ? COL_OVER :
          ov && hit ? COL_CONFLICT :
          ov ? COL_ACTIVE :
          hit ? COL_FILLED : COL_EMPTY;
  end
  // DONE spans two cycles: the last pixel's plot cycle, then the done pulse cycle,
  // so a start coinciding with done is still ignored.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= ST_IDLE;
      grid_s     <= '0;
      block_s    <= '0;
      ax_s       <= '0;
      ay_s       <= '0;
      go_s       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      vga_plot <= advance;
      done     <= state == ST_DONE && !done;
      if (advance) begin
        vga_x      <= sx;
        vga_y      <= sy;
        vga_colour <= col;
      end
      if (idle && start) begin
        grid_s  <= game_grid;
        block_s <= active_block;
        ax_s    <= active_x;
        ay_s    <= active_y;
        go_s    <= game_over;
        busy    <= 1'b1;
        state   <= ST_DRAW;
      end
      if (state == ST_DRAW && last) state <= ST_DONE;
      if (state == ST_DONE && done) begin
        busy  <= 1'b0;
        state <= ST_IDLE;
      end
    end
endmodule

// File: tb/tb_board_renderer.sv
// tb_board_renderer: directed self-checking bench for board_renderer
module tb_board_renderer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, game_over = 1'b0;
  logic [63:0] game_grid = '0, active_block = '0;
  logic [2:0]  active_x = '0, active_y = '0;
  logic        busy, done, vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  always #5 clk = ~clk;
  board_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .game_grid   (game_grid),
    .active_block(active_block),
    .active_x    (active_x),
    .active_y    (active_y),
    .game_over   (game_over),
    .busy        (busy),
    .done        (done),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot)
  );
  int n_cmp = 0, n_bad = 0;
  logic [2:0] fb [0:159][0:119];
  int plots, dones, done_cyc, first_cyc, last_cyc;
  logic [7:0] fx;
  logic [6:0] fy;
  logic busy1, busy_done, busy_after;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic frame(input int ev_at, input bit do_rst, input logic [63:0] grid_ev);
    plots = 0; dones = 0; done_cyc = 0; first_cyc = 0; last_cyc = 0;
    busy1 = 1'b0; busy_done = 1'b0; busy_after = 1'b1; fx = '0; fy = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int n = 1; n <= 9400; n++) begin
      if (vga_plot) begin
        if (vga_x < 160 && vga_y < 120) fb[vga_x][vga_y] = vga_colour;
        if (plots == 0) begin
          fx = vga_x; fy = vga_y; first_cyc = n;
        end
        plots++;
        last_cyc = n;
      end
      if (n == 1) busy1 = busy;
      if (done_cyc != 0 && n == done_cyc + 1) begin
        busy_after = busy;
        break;
      end
      if (done) begin
        dones++; done_cyc = n; busy_done = busy;
      end
      if (n == ev_at) begin
        if (do_rst) begin
          reset = 1'b1;
          #1;
          check("rst_plot_now", vga_plot, 0);
          check("rst_busy_now", busy, 0);
          @(negedge clk);
          check("rst_plot_held", vga_plot, 0);
          check("rst_busy_held", busy, 0);
          reset = 1'b0;
          repeat (20) begin
            @(negedge clk);
            if (done) dones++;
          end
          break;
        end
        game_grid = grid_ev;
        start = 1'b1;
      end
      @(negedge clk) start = 1'b0;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_plot", vga_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    reset = 1'b0;
    frame(0, 1'b0, '0);
    check("f1_plots", plots, 9216);
    check("f1_first_x", fx, 16);
    check("f1_first_y", fy, 16);
    check("f1_first_cyc", first_cyc, 1);
    check("f1_last_cyc", last_cyc, 9216);
    check("f1_dones", dones, 1);
    check("f1_done_cyc", done_cyc, 9217);
    check("f1_busy_c1", busy1, 1);
    check("f1_busy_done", busy_done, 1);
    check("f1_busy_after", busy_after, 0);
    check("f1_px_16_16", fb[16][16], 3'b000);
    check("f1_px_27_16", fb[27][16], 3'b111);
    check("f1_px_16_27", fb[16][27], 3'b111);
    check("f1_px_111_111", fb[111][111], 3'b111);
    check("f1_hold_x", vga_x, 111);
    check("f1_hold_y", vga_y, 111);
    game_grid = 64'h201;
    frame(0, 1'b0, '0);
    check("f2_px_16_16", fb[16][16], 3'b011);
    check("f2_px_28_28", fb[28][28], 3'b011);
    check("f2_px_40_40", fb[40][40], 3'b000);
    game_grid = 64'h1 << 62; active_block = 64'h3; active_x = 3'd6; active_y = 3'd7;
    frame(0, 1'b0, '0);
    check("f3_conflict", fb[88][100], 3'b100);
    check("f3_active", fb[100][100], 3'b110);
    check("f3_left_empty", fb[76][100], 3'b000);
    check("f3_above_empty", fb[88][88], 3'b000);
    active_block = 64'h7;
    frame(0, 1'b0, '0);
    check("f3b_no_wrap_r7c0", fb[16][100], 3'b000);
    check("f3b_no_wrap_r0c0", fb[16][16], 3'b000);
    check("f3b_active", fb[100][100], 3'b110);
    game_grid = 64'h1; active_block = 64'h2; active_x = '0; active_y = '0; game_over = 1'b1;
    frame(9217, 1'b0, 64'h1);
    check("f4_over", fb[16][16], 3'b101);
    check("f4_no_overlay", fb[28][16], 3'b000);
    check("f4_start_on_done_busy", busy_after, 0);
    check("f4_dones", dones, 1);
    game_over = 1'b0; active_block = '0;
    frame(100, 1'b0, ~64'h1);
    check("f5_plots", plots, 9216);
    check("f5_dones", dones, 1);
    check("f5_done_cyc", done_cyc, 9217);
    check("f5_snap_16_16", fb[16][16], 3'b011);
    check("f5_snap_28_28", fb[28][28], 3'b000);
    check("f5_snap_40_40", fb[40][40], 3'b000);
    game_grid = '0;
    frame(500, 1'b1, '0);
    check("f6_abort_dones", dones, 0);
    check("f6_abort_busy", busy, 0);
    frame(0, 1'b0, '0);
    check("f7_first_x", fx, 16);
    check("f7_first_y", fy, 16);
    check("f7_plots", plots, 9216);
    check("f7_dones", dones, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
